// File: rtl/instr_register_exec.sv
// instr_register_exec: DEPTH-entry store of {opcode, operand_a, operand_b}
// with a one-stage execute unit that writes each entry's signed result and
// divide-by-zero flag one cycle after the operands land. A registered read
// port forwards same-cycle writes and in-flight results so reads never see
// stale data.
module instr_register_exec #(
  parameter int DEPTH    = 32,
  parameter int OP_W     = 32,
  parameter int AUTO_INC = 0,
  localparam int PW      = $clog2(DEPTH),
  localparam int RES_W   = 2 * OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [PW-1:0]    write_pointer,
  input  logic [OP_W-1:0]  operand_a,
  input  logic [OP_W-1:0]  operand_b,
  input  logic [2:0]       opcode,
  input  logic             read_en,
  input  logic [PW-1:0]    read_pointer,
  output logic             rd_valid,
  output logic [2:0]       rd_opcode,
  output logic [OP_W-1:0]  rd_operand_a,
  output logic [OP_W-1:0]  rd_operand_b,
  output logic [RES_W-1:0] rd_result,
  output logic             rd_err,
  output logic [PW-1:0]    wr_ptr,
  output logic [PW:0]      loaded_cnt
);

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW:0]      loaded_cnt_reg;
  logic [PW-1:0]    wr_addr;

  // Execute stage: holds the result of the write accepted on the previous edge.
  logic             ex_valid_reg;
  logic [PW-1:0]    ex_addr_reg;
  logic [RES_W-1:0] ex_result_reg;
  logic             ex_err_reg;

  logic [RES_W-1:0] ex_result_next;
  logic             ex_err_next;

  logic signed [RES_W-1:0] ext_a;
  logic signed [RES_W-1:0] ext_b;

  // Per-entry storage views, gathered from the generate block for the read mux.
  logic [2:0]       ent_op      [DEPTH];
  logic [OP_W-1:0]  ent_a       [DEPTH];
  logic [OP_W-1:0]  ent_b       [DEPTH];
  logic [RES_W-1:0] ent_res     [DEPTH];
  logic             ent_err     [DEPTH];
  logic             ent_written [DEPTH];

  assign wr_addr    = (AUTO_INC != 0) ? wr_ptr_reg : write_pointer;
  assign wr_ptr     = wr_ptr_reg;
  assign loaded_cnt = loaded_cnt_reg;

  assign ext_a = {{OP_W{operand_a[OP_W-1]}}, operand_a};
  assign ext_b = {{OP_W{operand_b[OP_W-1]}}, operand_b};

  // Arithmetic on sign-extended operands; RES_W is wide enough that nothing overflows.
  always_comb begin
    ex_result_next = '0;
    ex_err_next    = 1'b0;
    case (opcode)
      OP_ZERO:  ex_result_next = '0;
      OP_PASSA: ex_result_next = ext_a;
      OP_PASSB: ex_result_next = ext_b;
      OP_ADD:   ex_result_next = ext_a + ext_b;
      OP_SUB:   ex_result_next = ext_a - ext_b;
      OP_MULT:  ex_result_next = ext_a * ext_b;
      OP_DIV: begin
        if (ext_b == '0) ex_err_next = 1'b1;
        else             ex_result_next = ext_a / ext_b;
      end
      OP_MOD: begin
        if (ext_b == '0) ex_err_next = 1'b1;
        else             ex_result_next = ext_a % ext_b;
      end
      default: ex_result_next = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [2:0]       op_reg;
      logic [OP_W-1:0]  a_reg;
      logic [OP_W-1:0]  b_reg;
      logic [RES_W-1:0] res_reg;
      logic             err_reg;
      logic             written_reg;

      // Operands land on the write edge; the result lands one edge later from the execute stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          op_reg      <= '0;
          a_reg       <= '0;
          b_reg       <= '0;
          res_reg     <= '0;
          err_reg     <= 1'b0;
          written_reg <= 1'b0;
        end else begin
          if (load_en && wr_addr == PW'(gi)) begin
            op_reg      <= opcode;
            a_reg       <= operand_a;
            b_reg       <= operand_b;
            written_reg <= 1'b1;
          end
          if (ex_valid_reg && ex_addr_reg == PW'(gi)) begin
            res_reg <= ex_result_reg;
            err_reg <= ex_err_reg;
          end
        end
      end

      assign ent_op[gi]      = op_reg;
      assign ent_a[gi]       = a_reg;
      assign ent_b[gi]       = b_reg;
      assign ent_res[gi]     = res_reg;
      assign ent_err[gi]     = err_reg;
      assign ent_written[gi] = written_reg;
    end
  endgenerate

  // Execute pipeline register, auto-increment pointer and first-write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg   <= 1'b0;
      ex_addr_reg    <= '0;
      ex_result_reg  <= '0;
      ex_err_reg     <= 1'b0;
      wr_ptr_reg     <= '0;
      loaded_cnt_reg <= '0;
    end else begin
      ex_valid_reg <= load_en;
      if (load_en) begin
        ex_addr_reg   <= wr_addr;
        ex_result_reg <= ex_result_next;
        ex_err_reg    <= ex_err_next;
        if (AUTO_INC != 0) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (!ent_written[wr_addr]) loaded_cnt_reg <= loaded_cnt_reg + 1'b1;
      end
    end
  end

  // Registered read port: same-cycle write beats in-flight result beats stored entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid     <= 1'b0;
      rd_opcode    <= '0;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
      rd_result    <= '0;
      rd_err       <= 1'b0;
    end else begin
      rd_valid <= read_en;
      if (read_en) begin
        if (load_en && wr_addr == read_pointer) begin
          rd_opcode    <= opcode;
          rd_operand_a <= operand_a;
          rd_operand_b <= operand_b;
          rd_result    <= ex_result_next;
          rd_err       <= ex_err_next;
        end else begin
          rd_opcode    <= ent_op[read_pointer];
          rd_operand_a <= ent_a[read_pointer];
          rd_operand_b <= ent_b[read_pointer];
          if (ex_valid_reg && ex_addr_reg == read_pointer) begin
            rd_result <= ex_result_reg;
            rd_err    <= ex_err_reg;
          end else begin
            rd_result <= ent_res[read_pointer];
            rd_err    <= ent_err[read_pointer];
          end
        end
      end
    end
  end

endmodule
